// File: rtl/ds_buf_en_ctrl.sv
// Power-up / qualification sequencer for a differential input buffer.
// Enables the buffer, waits a settle time, qualifies toggle activity on the
// buffer output, then reports ready; loss of activity or failed
// qualification latches a fault until the request is withdrawn.
module ds_buf_en_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CHECK_WINDOW  = 64,
    parameter int unsigned MIN_TOGGLES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_req,
    input  logic ds_o,
    output logic buf_en,
    output logic ready,
    output logic fault,
    output logic busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned WW = $clog2(CHECK_WINDOW) + 1;
    localparam int unsigned TW = $clog2(MIN_TOGGLES) + 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(CHECK_WINDOW - 1);
    localparam logic [TW-1:0] TOG_MAX     = TW'(MIN_TOGGLES);
    localparam logic [TW-1:0] TOG_LAST    = TW'(MIN_TOGGLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_READY,
        ST_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] win_q, win_d;
    logic [TW-1:0] tog_q, tog_d;
    logic [WW-1:0] idle_q, idle_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sync3_q, sync3_d;
    logic          toggle;

    // State, counters and synchronizer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            win_q    <= '0;
            tog_q    <= '0;
            idle_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            tog_q    <= tog_d;
            idle_q   <= idle_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
        end
    end

    // Next-state logic: synchronizer shift, sequencing and activity counters
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        tog_d    = tog_q;
        idle_d   = idle_q;
        sync1_d  = ds_o;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        toggle   = sync2_q ^ sync3_q;

        case (state_q)
            ST_IDLE: begin
                if (en_req) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                // toggles are deliberately ignored while the buffer settles
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                    win_d   = '0;
                    tog_d   = '0;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_CHECK: begin
                win_d = win_q + WW'(1);
                if (toggle && (tog_q != TOG_MAX)) begin
                    tog_d = tog_q + TW'(1);
                end
                // a qualifying toggle in the final window cycle still wins
                if (toggle && (tog_q == TOG_LAST)) begin
                    state_d = ST_READY;
                    idle_d  = '0;
                end else if (win_q == WIN_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_READY: begin
                if (toggle) begin
                    idle_d = '0;
                end else if (idle_q == WIN_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    idle_d = idle_q + WW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // withdrawing the request overrides every other transition
        if (!en_req) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            win_d    = '0;
            tog_d    = '0;
            idle_d   = '0;
        end
    end

    // Outputs decoded straight from the state register
    always_comb begin
        buf_en = 1'b0;
        ready  = 1'b0;
        fault  = 1'b0;
        busy   = 1'b0;
        case (state_q)
            ST_SETTLE, ST_CHECK: begin
                buf_en = 1'b1;
                busy   = 1'b1;
            end
            ST_READY: begin
                buf_en = 1'b1;
                ready  = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                buf_en = 1'b0;
            end
        endcase
    end

endmodule
